// File: rtl/vector_alu_pkg.sv
// Shared types and default widths for the vector scaler.
//   scale_mode_e : per-lane scale factor select (x1, x1.5, x1.25, x1.125)
//   DEF_*        : default parameter values for vector_scale_pipe
package vector_alu_pkg;

  typedef enum logic [1:0] {
    SCL_X1     = 2'b00,
    SCL_X1P5   = 2'b01,
    SCL_X1P25  = 2'b10,
    SCL_X1P125 = 2'b11
  } scale_mode_e;

  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned DEF_IN_W  = 20;
  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 23;

endpackage

// File: rtl/vector_scale_pipe_scale_lane.sv
// Per-lane combinational datapath for the scaler.
// Stage-1 section: magnitude + mode -> scaled sum S = 8m + A.
// Stage-2 section: S + sign + exponent -> {sign,exp,man} word with carry
// normalisation, exponent saturation and zero handling.
// Ports:
//   i_mag, i_mode -> o_sum           (stage-1 function)
//   i_sign, i_sum, i_exp -> o_word, o_sat (stage-2 function)
module scale_lane
  import vector_alu_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input  logic [IN_W-2:0]          i_mag,
  input  scale_mode_e              i_mode,
  output logic [MAN_W:0]           o_sum,
  input  logic                     i_sign,
  input  logic [MAN_W:0]           i_sum,
  input  logic [EXP_W-1:0]         i_exp,
  output logic [EXP_W+MAN_W:0]     o_word,
  output logic                     o_sat
);

  localparam int unsigned SUM_W = MAN_W + 1;

  logic [SUM_W-1:0] w_m;
  logic [SUM_W-1:0] w_add;
  logic             w_carry;
  logic [MAN_W-1:0] w_man;
  logic [EXP_W:0]   w_e;
  logic [EXP_W:0]   w_e_lim;
  logic [EXP_W-1:0] w_e_sat;

  // Stage 1: scale by 8 plus the mode-selected addend; S carries 3 fraction bits of headroom.
  always_comb begin
    w_m   = SUM_W'(i_mag);
    w_add = '0;
    unique case (i_mode)
      SCL_X1:     w_add = '0;
      SCL_X1P5:   w_add = w_m << 2;
      SCL_X1P25:  w_add = w_m << 1;
      SCL_X1P125: w_add = w_m;
      default:    w_add = '0;
    endcase
    o_sum = (w_m << 3) + w_add;
  end

  // Stage 2: normalise the carry, saturate the exponent, zero overrides everything.
  always_comb begin
    w_e_lim = (EXP_W+1)'({EXP_W{1'b1}});
    w_e_sat = {{(EXP_W-1){1'b1}}, 1'b0};
    w_carry = i_sum[SUM_W-1];
    w_man   = w_carry ? i_sum[SUM_W-1:1] : i_sum[MAN_W-1:0];
    w_e     = (EXP_W+1)'(i_exp) + (EXP_W+1)'(w_carry);
    o_word  = {i_sign, w_e[EXP_W-1:0], w_man};
    o_sat   = 1'b0;
    if (i_sum == '0) begin
      o_word = {i_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end else if (w_e >= w_e_lim) begin
      o_word = {i_sign, w_e_sat, {MAN_W{1'b1}}};
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/vector_scale_pipe.sv
// Multi-lane two-stage pipelined scaler: sign-magnitude lanes in,
// {sign,exp,man} words out, valid/ready on both sides.
// Optional feature macro: VSCALE_SAT_CNT_EN adds the sat_cnt port and a
// saturating count of saturated lanes delivered downstream.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake (in_ready combinational)
//   in_data, in_mode      lane payload and per-lane scale mode
//   in_exp                exponent shared by the transaction
//   out_valid/out_ready   output handshake
//   out_data, out_sat     lane words and per-lane saturation flags
//   sat_cnt               saturated-lane counter (VSCALE_SAT_CNT_EN only)
module vector_scale_pipe
  import vector_alu_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*IN_W-1:0]          in_data,
  input  logic [LANES*2-1:0]             in_mode,
  input  logic [EXP_W-1:0]               in_exp,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0] out_data,
  output logic [LANES-1:0]               out_sat
`ifdef VSCALE_SAT_CNT_EN
  ,
  output logic [15:0]                    sat_cnt
`endif
);

  localparam int unsigned SUM_W  = MAN_W + 1;
  localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;

  if (IN_W > MAN_W - 2) begin : g_bad_cfg
    $error("vector_scale_pipe: IN_W must be <= MAN_W-2");
  end

  logic                          r_v1;
  logic [LANES-1:0]              r_s1_sign;
  logic [LANES-1:0][SUM_W-1:0]   r_s1_sum;
  logic [EXP_W-1:0]              r_s1_exp;
  logic                          r_v2;
  logic [LANES-1:0][WORD_W-1:0]  r_out_word;
  logic [LANES-1:0]              r_out_sat;

  logic [LANES-1:0][SUM_W-1:0]   w_sum;
  logic [LANES-1:0][WORD_W-1:0]  w_word;
  logic [LANES-1:0]              w_sat;
  logic                          w_ld1;
  logic                          w_ld2;

  // A stage loads when it is empty or its successor is taking its contents.
  assign w_ld2    = !r_v2 || out_ready;
  assign w_ld1    = !r_v1 || w_ld2;
  assign in_ready = w_ld1;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    scale_lane #(
      .IN_W  (IN_W),
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
    ) u_lane (
      .i_mag  (in_data[i*IN_W +: IN_W-1]),
      .i_mode (scale_mode_e'(in_mode[2*i +: 2])),
      .o_sum  (w_sum[i]),
      .i_sign (r_s1_sign[i]),
      .i_sum  (r_s1_sum[i]),
      .i_exp  (r_s1_exp),
      .o_word (w_word[i]),
      .o_sat  (w_sat[i])
    );
  end

  // Stage 1 register: scaled sums, signs and shared exponent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_s1_sign <= '0;
      r_s1_sum  <= '0;
      r_s1_exp  <= '0;
    end else if (w_ld1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < LANES; i++) begin
          r_s1_sign[i] <= in_data[i*IN_W + IN_W - 1];
        end
        r_s1_sum <= w_sum;
        r_s1_exp <= in_exp;
      end
    end
  end

  // Stage 2 register: final words; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2       <= 1'b0;
      r_out_word <= '0;
      r_out_sat  <= '0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_out_word <= w_word;
        r_out_sat  <= w_sat;
      end
    end
  end

  assign out_valid = r_v2;
  assign out_data  = r_out_word;
  assign out_sat   = r_out_sat;

`ifdef VSCALE_SAT_CNT_EN
  logic [15:0] r_sat_cnt;
  logic [15:0] w_pop;
  logic [16:0] w_cnt_sum;

  // Popcount of saturated lanes handed downstream this cycle.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + 16'(r_out_sat[i]);
    end
    w_cnt_sum = 17'(r_sat_cnt) + 17'(w_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (r_v2 && out_ready) begin
      r_sat_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule
